regfile_arbiter: RTL and testbench
==================================

// Module: regfile_arbiter
// PURPOSE
//  Two-requester round-robin arbiter and sequencer in front of the 256x8 register file.
//  Shares the file's read port and write port between requesters A and B, one access per cycle.
//  Supports locked bursts of up to MAX_BURST back-to-back accesses.
//  Returns read data registered, one cycle after the grant.
// PARAMETERS
//  ADDR_W     8  register-file address width
//  DATA_W     8  register-file data width
//  MAX_BURST  4  max consecutive grants to one locked owner (legal 1..16)
// PORTS
//  Clk        in   1       clock, all state on rising edge
//  Rst        in   1       asynchronous, active-low reset
//  A_Req      in   1       A requests an access; held until A_Gnt
//  A_Wr       in   1       1 = write, 0 = read (valid while A_Req)
//  A_Lock     in   1       1 = keep ownership after this beat (burst)
//  A_Addr     in   ADDR_W  A access address
//  A_WData    in   DATA_W  A write data
//  A_Gnt      out  1       combinational; access performed this cycle
//  A_RValid   out  1       registered; A_RData valid (cycle after a read grant)
//  A_RData    out  DATA_W  registered read data for A
//  B_*        (same set as A_*, for requester B)
//  RF_R_en    out  1       register-file read enable
//  RF_R_Addr  out  ADDR_W  register-file read address
//  RF_R_Data  in   DATA_W  register-file read data (combinational; Z when RF_R_en=0)
//  RF_W_en    out  1       register-file write enable
//  RF_W_Addr  out  ADDR_W  register-file write address
//  RF_W_Data  out  DATA_W  register-file write data
// BEHAVIOUR
//  Reset (Rst=0, async): state=IDLE, last=B (A wins first tie), burst cnt=0.
//   Reset values: *_RValid=0, *_RData=0. Gnt, RF_R_en and RF_W_en are forced 0 while Rst=0.
//  FSM states: IDLE, OWN_A, OWN_B. Burst counter cnt, width clog2(MAX_BURST)+1.
//  IDLE:
//   - Only one Req: grant it.
//   - Both Req: grant the requester that is not "last".
//   - No Req: no grant.
//  OWN_x:
//   - Only x may be granted. The other requester waits, even if it is requesting.
//   - If Req_x=0: the cycle is evaluated as IDLE (the other may be granted), then next=IDLE.
//  On any grant to x:
//   - last<=x.
//   - If Lock_x=1 and the beat count including this grant < MAX_BURST:
//     next=OWN_x, cnt<=cnt+1 (cnt<=1 when entering from IDLE).
//   - Otherwise: next=IDLE, cnt<=0.
//   - MAX_BURST=1 means Lock is ignored.
//  Grant cycle, write: RF_W_en=1, RF_W_Addr/RF_W_Data = x's Addr/WData; the file updates at that edge.
//  Grant cycle, read: RF_R_en=1, RF_R_Addr=x's Addr.
//   - RF_R_Data is captured into x_RData at the edge; x_RValid=1 for exactly the next cycle.
//   - x_RData holds its value until the next read for x.
//  Non-grant cycles: RF_R_en=0, RF_W_en=0. Address/data outputs are don't-care; drive 0.
//  Read latency: 1 cycle after grant. Back-to-back reads yield RValid every cycle.
//  Write then read of the same address on consecutive grants returns the new data.
//  At most one RF access per cycle, so no read/write collision is possible.
//  Reset mid-burst: ownership is dropped and a pending RValid is cleared; requesters must re-request.
//  Gnt depends only on state, last, Req and Rst; it has no combinational path from Lock, Wr, Addr or data.
// TESTING
//  1 Reset, then A_Req=1 read addr 0x27: A_Gnt same cycle, RF_R_en=1;
//    next cycle A_RValid=1 with A_RData=RF value (e.g. 0xFA).
//  2 A_Req and B_Req both held for 4 cycles, Lock=0: grants A,B,A,B; RValid follows each read by 1 cycle.
//  3 A_Lock=1, 6-beat write burst to 0x00..0x05 while B_Req=1 (MAX_BURST=4):
//    A granted 4 cycles, then B granted, then A resumes.
//  4 Owner A drops Req mid-burst while B_Req=1: B granted that same cycle, state returns to IDLE.
//  5 A writes 0x5A to 0x10, then reads 0x10 on the next cycle: A_RData=0x5A.
//    RF_W_en and RF_R_en are never both 1 in any cycle.
//  6 Assert Rst=0 during an A burst with a read outstanding:
//    Gnt/RValid/RF enables go 0 immediately; after release, B tie-break loses to A.

Source files
------------

// File: rtl/regfile_arbiter.sv
// Round-robin arbiter/sequencer sharing one register file between requesters A and B.
// Supports locked bursts up to MAX_BURST beats and returns registered read data.
module regfile_arbiter #(
    parameter int ADDR_W    = 8,
    parameter int DATA_W    = 8,
    parameter int MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              a_req,
    input  logic              a_wr,
    input  logic              a_lock,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [DATA_W-1:0] a_wdata,
    output logic              a_gnt,
    output logic              a_rvalid,
    output logic [DATA_W-1:0] a_rdata,
    input  logic              b_req,
    input  logic              b_wr,
    input  logic              b_lock,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [DATA_W-1:0] b_wdata,
    output logic              b_gnt,
    output logic              b_rvalid,
    output logic [DATA_W-1:0] b_rdata,
    output logic              rf_r_en,
    output logic [ADDR_W-1:0] rf_r_addr,
    input  logic [DATA_W-1:0] rf_r_data,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_w_addr,
    output logic [DATA_W-1:0] rf_w_data
);
    localparam int CNT_W = $clog2(MAX_BURST) + 1;
    localparam logic [CNT_W-1:0] MAX_B = CNT_W'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, OWN_A, OWN_B} state_t;

    state_t           state, state_nxt;
    logic             last_b, last_b_nxt;
    logic [CNT_W-1:0] cnt, cnt_nxt;
    logic [CNT_W-1:0] beats;

    // State register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            last_b <= 1'b1;
            cnt    <= '0;
        end else begin
            state  <= state_nxt;
            last_b <= last_b_nxt;
            cnt    <= cnt_nxt;
        end
    end

    // Grant: an owner that dropped Req falls through to the idle tie-break
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (state == OWN_A && a_req)       a_gnt = 1'b1;
        else if (state == OWN_B && b_req)  b_gnt = 1'b1;
        else if (a_req && (!b_req || last_b)) a_gnt = 1'b1;
        else if (b_req)                    b_gnt = 1'b1;
        if (!rst_n) begin
            a_gnt = 1'b0;
            b_gnt = 1'b0;
        end
    end

    // Next state: beat count includes the grant happening this cycle
    always_comb begin
        state_nxt  = IDLE;
        cnt_nxt    = '0;
        last_b_nxt = last_b;
        beats      = CNT_W'(1);
        if (a_gnt) begin
            last_b_nxt = 1'b0;
            if (state == OWN_A) beats = cnt + CNT_W'(1);
            if (a_lock && beats < MAX_B) begin
                state_nxt = OWN_A;
                cnt_nxt   = beats;
            end
        end else if (b_gnt) begin
            last_b_nxt = 1'b1;
            if (state == OWN_B) beats = cnt + CNT_W'(1);
            if (b_lock && beats < MAX_B) begin
                state_nxt = OWN_B;
                cnt_nxt   = beats;
            end
        end
    end

    // Register-file port steering
    always_comb begin
        rf_r_en   = 1'b0;
        rf_r_addr = '0;
        rf_w_en   = 1'b0;
        rf_w_addr = '0;
        rf_w_data = '0;
        if (a_gnt) begin
            if (a_wr) begin
                rf_w_en   = 1'b1;
                rf_w_addr = a_addr;
                rf_w_data = a_wdata;
            end else begin
                rf_r_en   = 1'b1;
                rf_r_addr = a_addr;
            end
        end else if (b_gnt) begin
            if (b_wr) begin
                rf_w_en   = 1'b1;
                rf_w_addr = b_addr;
                rf_w_data = b_wdata;
            end else begin
                rf_r_en   = 1'b1;
                rf_r_addr = b_addr;
            end
        end
    end

    // Read return: data held until the next read for the same requester
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_rvalid <= 1'b0;
            a_rdata  <= '0;
            b_rvalid <= 1'b0;
            b_rdata  <= '0;
        end else begin
            a_rvalid <= a_gnt && !a_wr;
            b_rvalid <= b_gnt && !b_wr;
            if (a_gnt && !a_wr) a_rdata <= rf_r_data;
            if (b_gnt && !b_wr) b_rdata <= rf_r_data;
        end
    end
endmodule

// File: tb/tb_regfile_arbiter.sv
// Bench for regfile_arbiter: directed scenarios plus random traffic, checked
// cycle by cycle against an ownership/beat-count reference model and a shadow memory.
module tb_regfile_arbiter;
    localparam int MB = 4;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       a_req, a_wr, a_lock, b_req, b_wr, b_lock;
    logic [7:0] a_addr, a_wdata, b_addr, b_wdata;
    logic       a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [7:0] a_rdata, b_rdata;
    logic       rf_r_en, rf_w_en;
    logic [7:0] rf_r_addr, rf_r_data, rf_w_addr, rf_w_data;

    always #5 clk = ~clk;

    regfile_arbiter #(.ADDR_W(8), .DATA_W(8), .MAX_BURST(MB)) dut (
        .clk(clk), .rst_n(rst_n),
        .a_req(a_req), .a_wr(a_wr), .a_lock(a_lock), .a_addr(a_addr), .a_wdata(a_wdata),
        .a_gnt(a_gnt), .a_rvalid(a_rvalid), .a_rdata(a_rdata),
        .b_req(b_req), .b_wr(b_wr), .b_lock(b_lock), .b_addr(b_addr), .b_wdata(b_wdata),
        .b_gnt(b_gnt), .b_rvalid(b_rvalid), .b_rdata(b_rdata),
        .rf_r_en(rf_r_en), .rf_r_addr(rf_r_addr), .rf_r_data(rf_r_data),
        .rf_w_en(rf_w_en), .rf_w_addr(rf_w_addr), .rf_w_data(rf_w_data)
    );

    // Register file driven by the DUT, and the model's own shadow copy
    logic [7:0] mem [256];
    logic [7:0] ref_mem [256];
    assign rf_r_data = rf_r_en ? mem[rf_r_addr] : 8'hzz;

    int checks = 0, errors = 0;

    // Reference model: owner 0=none 1=A 2=B, beats already taken by that owner
    int         own, beats;
    bit         last_b;
    bit         exp_arv, exp_brv;
    logic [7:0] exp_ard, exp_brd;
    bit         ga, gb;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Called at a negedge with inputs already set; returns at the following negedge
    task automatic step();
        bit rd, wr, wen_s;
        logic [7:0] addr, wd, wa_s, wdat_s;
        int who, nb;
        bit lk;
        if (!rst_n) begin
            own = 0; beats = 0; last_b = 1;
            exp_arv = 0; exp_brv = 0; exp_ard = 0; exp_brd = 0;
        end
        #1;
        ga = 0; gb = 0;
        if (rst_n) begin
            if (own == 1 && a_req)                  ga = 1;
            else if (own == 2 && b_req)             gb = 1;
            else if (a_req && (!b_req || last_b))   ga = 1;
            else if (b_req)                         gb = 1;
        end
        rd   = (ga && !a_wr) || (gb && !b_wr);
        wr   = (ga && a_wr) || (gb && b_wr);
        addr = ga ? a_addr : b_addr;
        wd   = ga ? a_wdata : b_wdata;
        chk("a_gnt", a_gnt, ga);
        chk("b_gnt", b_gnt, gb);
        chk("a_rvalid", a_rvalid, exp_arv);
        chk("b_rvalid", b_rvalid, exp_brv);
        chk("a_rdata", a_rdata, exp_ard);
        chk("b_rdata", b_rdata, exp_brd);
        chk("rf_r_en", rf_r_en, rd);
        chk("rf_w_en", rf_w_en, wr);
        chk("rf_r_addr", rf_r_addr, rd ? addr : 8'h00);
        chk("rf_w_addr", rf_w_addr, wr ? addr : 8'h00);
        chk("rf_w_data", rf_w_data, wr ? wd : 8'h00);
        wen_s = rf_w_en; wa_s = rf_w_addr; wdat_s = rf_w_data;

        exp_arv = ga && !a_wr;
        exp_brv = gb && !b_wr;
        if (exp_arv) exp_ard = ref_mem[a_addr];
        if (exp_brv) exp_brd = ref_mem[b_addr];
        if (wr) ref_mem[addr] = wd;
        if (ga || gb) begin
            who    = ga ? 1 : 2;
            lk     = ga ? a_lock : b_lock;
            nb     = (own == who) ? beats + 1 : 1;
            last_b = gb;
            if (lk && nb < MB) begin own = who; beats = nb; end
            else begin own = 0; beats = 0; end
        end else begin
            own = 0; beats = 0;
        end

        @(posedge clk);
        #1;
        if (wen_s) mem[wa_s] = wdat_s;
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        a_req = 0; a_wr = 0; a_lock = 0; a_addr = 0; a_wdata = 0;
        b_req = 0; b_wr = 0; b_lock = 0; b_addr = 0; b_wdata = 0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_n = 0;
        step();
        step();
        rst_n = 1;
    endtask

    logic [6:0] pat;
    bit pa, pb;

    initial begin
        for (int i = 0; i < 256; i++) begin
            mem[i]     = 8'($urandom);
            ref_mem[i] = mem[i];
        end
        mem[8'h27] = 8'hFA; ref_mem[8'h27] = 8'hFA;
        idle_inputs();
        rst_n = 0;
        @(negedge clk);
        do_reset();

        // 1: single read returns registered data one cycle later
        a_req = 1; a_addr = 8'h27;
        step();
        a_req = 0;
        chk("t1_rdata", a_rdata, 8'hFA);
        step();

        // 2: both requesting, no lock -> strict alternation starting with A
        do_reset();
        a_req = 1; b_req = 1; a_addr = 8'h01; b_addr = 8'h02;
        pat = '0;
        for (int i = 0; i < 4; i++) begin
            step();
            pat[3-i] = a_gnt ^ ga ^ ga;
            pat[3-i] = ga;
            if (ga) a_addr = 8'($urandom);
            if (gb) b_addr = 8'($urandom);
        end
        chk("t2_pattern", {28'd0, pat[3:0]}, 32'hA);
        idle_inputs();
        step();

        // 3: locked 6-beat write burst is cut at MAX_BURST to let B in
        do_reset();
        a_req = 1; a_wr = 1; a_lock = 1; a_addr = 8'h00; a_wdata = 8'($urandom);
        b_req = 1; b_addr = 8'h80;
        for (int i = 0; i < 7; i++) begin
            step();
            pat[6-i] = ga;
            if (ga) begin
                a_addr  = a_addr + 8'd1;
                a_wdata = 8'($urandom);
                if (a_addr == 8'd6) a_req = 0;
            end
            if (gb) b_req = 0;
        end
        chk("t3_pattern", {25'd0, pat}, 32'h7B);
        idle_inputs();
        step();

        // 4: owner drops Req mid-burst, waiting B is granted that same cycle
        do_reset();
        a_req = 1; a_lock = 1; a_addr = 8'h30; b_req = 1; b_addr = 8'h31;
        step();
        step();
        a_req = 0;
        step();
        b_req = 0; a_req = 1; a_lock = 0;
        step();
        idle_inputs();
        step();

        // 5: write then read of the same address sees the new value
        a_req = 1; a_wr = 1; a_addr = 8'h10; a_wdata = 8'h5A;
        step();
        a_wr = 0;
        step();
        a_req = 0;
        chk("t5_rdata", a_rdata, 8'h5A);
        step();

        // 6: reset mid-burst with a read outstanding, then A wins the tie
        a_req = 1; a_lock = 1; a_addr = 8'h40; b_req = 1; b_addr = 8'h41;
        step();
        step();
        rst_n = 0;
        step();
        rst_n = 1;
        step();
        step();
        idle_inputs();
        step();

        // Random traffic with occasional resets
        pa = 0; pb = 0;
        for (int n = 0; n < 800; n++) begin
            if (!pa && ($urandom % 4) != 0) begin
                pa = 1; a_wr = 1'($urandom); a_lock = ($urandom % 3) != 0;
                a_addr = 8'($urandom % 16); a_wdata = 8'($urandom);
            end
            if (!pb && ($urandom % 4) != 0) begin
                pb = 1; b_wr = 1'($urandom); b_lock = ($urandom % 3) != 0;
                b_addr = 8'($urandom % 16); b_wdata = 8'($urandom);
            end
            a_req = pa; b_req = pb;
            rst_n = ($urandom % 150) != 0;
            step();
            if (ga || !rst_n) pa = 0;
            if (gb || !rst_n) pb = 0;
        end
        rst_n = 1;
        idle_inputs();
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
